// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared FSM states, funct3 size codes and endianness constants for the load/store unit
`ifndef RISCV_BIG_ENDIAN
`define RISCV_BIG_ENDIAN 1
`endif
`ifndef RISCV_LITTLE_ENDIAN
`define RISCV_LITTLE_ENDIAN 0
`endif
package riscv_lsu_pkg;
  localparam int LSU_LITTLE_ENDIAN = `RISCV_LITTLE_ENDIAN;
  localparam int LSU_BIG_ENDIAN    = `RISCV_BIG_ENDIAN;
  localparam logic [1:0] SZ_D   = 2'b11;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_RSP  = ST_RSP,
    S_DONE = ST_DONE
  } lsu_state_e;
endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: combinational size check, lane steering, byte enables and load extension
// Ports: i_we/i_funct3/i_lane describe the access, i_wr_data is right-aligned store data,
// i_rd_data is the raw bus word; o_unsup/o_misaligned flag illegal accesses,
// o_wr_be/o_wr_data are the steered store, o_rd_ext is the extended load result.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int MP_DATA_WIDTH = 32,
  parameter int MP_ENDIANESS  = LSU_BIG_ENDIAN,
  localparam int BE = MP_DATA_WIDTH / 8,
  localparam int LW = $clog2(BE)
) (
  input  logic                     i_we,
  input  logic [2:0]               i_funct3,
  input  logic [LW-1:0]            i_lane,
  input  logic [MP_DATA_WIDTH-1:0] i_wr_data,
  input  logic [MP_DATA_WIDTH-1:0] i_rd_data,
  output logic                     o_unsup,
  output logic                     o_misaligned,
  output logic [BE-1:0]            o_wr_be,
  output logic [MP_DATA_WIDTH-1:0] o_wr_data,
  output logic [MP_DATA_WIDTH-1:0] o_rd_ext
);
  localparam bit WIDE = (MP_DATA_WIDTH == 64);
  logic [3:0]               w_bytes;
  logic [15:0]              w_bm;
  logic [7:0]               w_off;
  logic [MP_DATA_WIDTH-1:0] w_fmask, w_msb, w_field;
  logic                     w_sign;
  assign w_bytes = 4'd1 << i_funct3[1:0];
  assign w_bm    = (16'd1 << w_bytes) - 16'd1;
  // The access is one contiguous bit field; big endian counts it down from the top of the bus.
  assign w_off   = (MP_ENDIANESS == LSU_BIG_ENDIAN) ? 8'((BE - int'(i_lane) - int'(w_bytes)) * 8)
                                                    : 8'(int'(i_lane) * 8);
  assign w_fmask = ~({MP_DATA_WIDTH{1'b1}} << (8 * w_bytes));
  assign w_msb   = w_fmask ^ (w_fmask >> 1);
  assign w_field = (i_rd_data >> w_off) & w_fmask;
  assign w_sign  = ~i_funct3[2] & |(w_field & w_msb);
  assign o_unsup = i_we ? (i_funct3[2] | (i_funct3[1:0] == SZ_D && !WIDE))
                        : (i_funct3 == F3_BAD || ((i_funct3 == F3_D || i_funct3 == F3_WU) && !WIDE));
  assign o_misaligned = ~o_unsup & |(i_lane & LW'(w_bytes - 4'd1));
  // Enables follow address lanes, independent of where the lanes sit on the bus.
  assign o_wr_be   = i_we ? (BE'(w_bm) << i_lane) : '0;
  assign o_wr_data = (i_wr_data & w_fmask) << w_off;
  assign o_rd_ext  = w_field | (w_sign ? ~w_fmask : '0);
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: MEM-stage load/store unit with request/grant/response memory port and timeout
// Ports: iclk/irst clock and sync reset; ireq_* and iaddr/iwr_data/ifunct3 from the MEM stage;
// ostall to the hazard unit; ord_* completion results; odmem_*/idmem_* memory handshake.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int MP_DATA_WIDTH     = 32,
  parameter int MP_ADDR_WIDTH     = 32,
  parameter int MP_ENDIANESS      = `RISCV_BIG_ENDIAN,
  parameter int MP_TIMEOUT_CYCLES = 255,
  localparam int BE = MP_DATA_WIDTH / 8
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic                     ireq_valid,
  input  logic                     ireq_we,
  input  logic [2:0]               ifunct3,
  input  logic [MP_ADDR_WIDTH-1:0] iaddr,
  input  logic [MP_DATA_WIDTH-1:0] iwr_data,
  output logic                     ostall,
  output logic                     ord_valid,
  output logic [MP_DATA_WIDTH-1:0] ord_data,
  output logic                     omisaligned,
  output logic                     oerr,
  output logic                     odmem_req,
  output logic [MP_ADDR_WIDTH-1:0] odmem_addr,
  output logic                     odmem_wr_en,
  output logic [BE-1:0]            odmem_wr_be,
  output logic [MP_DATA_WIDTH-1:0] odmem_wr_data,
  input  logic                     idmem_gnt,
  input  logic                     idmem_rsp_valid,
  input  logic [MP_DATA_WIDTH-1:0] idmem_rd_data,
  input  logic                     idmem_err
);
  localparam int LW = $clog2(BE);
  localparam int CW = $clog2(MP_TIMEOUT_CYCLES + 1);
  lsu_state_e               r_state;
  logic [CW-1:0]            r_cnt;
  logic                     r_we, r_mis, r_err;
  logic [2:0]               r_f3;
  logic [MP_ADDR_WIDTH-1:0] r_addr;
  logic [MP_DATA_WIDTH-1:0] r_wdata, r_data;
  logic                     w_idle, w_we, w_unsup, w_mis, w_tmo;
  logic [2:0]               w_f3;
  logic [LW-1:0]            w_lane;
  logic [MP_DATA_WIDTH-1:0] w_wdata, w_st_data, w_rd_ext;
  logic [BE-1:0]            w_be;
  // Checks run on the live request in IDLE, steering on the latched copy afterwards.
  assign w_idle  = r_state == S_IDLE;
  assign w_we    = w_idle ? ireq_we : r_we;
  assign w_f3    = w_idle ? ifunct3 : r_f3;
  assign w_lane  = w_idle ? iaddr[LW-1:0] : r_addr[LW-1:0];
  assign w_wdata = w_idle ? iwr_data : r_wdata;
  assign w_tmo   = r_cnt >= CW'(MP_TIMEOUT_CYCLES - 1);
  riscv_lsu_align #(
    .MP_DATA_WIDTH(MP_DATA_WIDTH),
    .MP_ENDIANESS (MP_ENDIANESS)
  ) u_align (
    .i_we        (w_we),
    .i_funct3    (w_f3),
    .i_lane      (w_lane),
    .i_wr_data   (w_wdata),
    .i_rd_data   (idmem_rd_data),
    .o_unsup     (w_unsup),
    .o_misaligned(w_mis),
    .o_wr_be     (w_be),
    .o_wr_data   (w_st_data),
    .o_rd_ext    (w_rd_ext)
  );
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (ireq_valid) begin
            r_we    <= ireq_we;
            r_f3    <= ifunct3;
            r_addr  <= iaddr;
            r_wdata <= iwr_data;
            r_data  <= '0;
            r_mis   <= w_mis;
            r_err   <= w_unsup;
            r_state <= (w_mis || w_unsup) ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (idmem_gnt) begin
            r_state <= S_RSP;
          end
        end
        S_RSP: begin
          r_cnt <= r_cnt + 1'b1;
          // A response in the final allowed cycle still wins over the timeout.
          if (idmem_rsp_valid) begin
            r_err   <= idmem_err;
            r_data  <= (r_we || idmem_err) ? '0 : w_rd_ext;
            r_state <= S_DONE;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign ostall        = ireq_valid && r_state != S_DONE;
  assign ord_valid     = r_state == S_DONE;
  assign ord_data      = ord_valid ? r_data : '0;
  assign omisaligned   = ord_valid & r_mis;
  assign oerr          = ord_valid & r_err;
  assign odmem_req     = r_state == S_REQ;
  assign odmem_addr    = odmem_req ? {r_addr[MP_ADDR_WIDTH-1:LW], {LW{1'b0}}} : '0;
  assign odmem_wr_en   = odmem_req & r_we;
  assign odmem_wr_be   = odmem_wr_en ? w_be : '0;
  assign odmem_wr_data = odmem_wr_en ? w_st_data : '0;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: vector table, hand sequences and random traffic against a byte-level reference model
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic        sel = 0, req_valid = 0, we = 0, gnt = 0, rsp = 0, derr = 0;
  logic [2:0]  f3 = 0;
  logic [31:0] addr = 0;
  logic [63:0] wd = 0, rd = 0;
  logic        a_stall, a_valid, a_mis, a_err, a_req, a_wen;
  logic [31:0] a_data, a_addr, a_wd;
  logic [3:0]  a_be;
  logic        b_stall, b_valid, b_mis, b_err, b_req, b_wen;
  logic [63:0] b_data, b_wd;
  logic [31:0] b_addr;
  logic [7:0]  b_be;
  riscv_lsu #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32), .MP_ENDIANESS(LSU_LITTLE_ENDIAN), .MP_TIMEOUT_CYCLES(4)) dut32 (
    .iclk(clk), .irst(rst), .ireq_valid(req_valid & ~sel), .ireq_we(we), .ifunct3(f3), .iaddr(addr),
    .iwr_data(wd[31:0]), .ostall(a_stall), .ord_valid(a_valid), .ord_data(a_data), .omisaligned(a_mis),
    .oerr(a_err), .odmem_req(a_req), .odmem_addr(a_addr), .odmem_wr_en(a_wen), .odmem_wr_be(a_be),
    .odmem_wr_data(a_wd), .idmem_gnt(gnt & ~sel), .idmem_rsp_valid(rsp & ~sel), .idmem_rd_data(rd[31:0]),
    .idmem_err(derr));
  riscv_lsu #(.MP_DATA_WIDTH(64), .MP_ADDR_WIDTH(32), .MP_ENDIANESS(LSU_BIG_ENDIAN)) dut64 (
    .iclk(clk), .irst(rst), .ireq_valid(req_valid & sel), .ireq_we(we), .ifunct3(f3), .iaddr(addr),
    .iwr_data(wd), .ostall(b_stall), .ord_valid(b_valid), .ord_data(b_data), .omisaligned(b_mis),
    .oerr(b_err), .odmem_req(b_req), .odmem_addr(b_addr), .odmem_wr_en(b_wen), .odmem_wr_be(b_be),
    .odmem_wr_data(b_wd), .idmem_gnt(gnt & sel), .idmem_rsp_valid(rsp & sel), .idmem_rd_data(rd),
    .idmem_err(derr));
  wire        o_stall = sel ? b_stall : a_stall;
  wire        o_valid = sel ? b_valid : a_valid;
  wire        o_mis   = sel ? b_mis : a_mis;
  wire        o_err   = sel ? b_err : a_err;
  wire        o_req   = sel ? b_req : a_req;
  wire        o_wen   = sel ? b_wen : a_wen;
  wire [63:0] o_data  = sel ? b_data : {32'b0, a_data};
  wire [31:0] o_addr  = sel ? b_addr : a_addr;
  wire [7:0]  o_be    = sel ? b_be : {4'b0, a_be};
  wire [63:0] o_wd    = sel ? b_wd : {32'b0, a_wd};
  typedef struct {
    bit sel, we, e, both;
    logic [2:0] f3;
    logic [31:0] addr;
    logic [63:0] wd, rd;
    int d1, d2;
    int x_done;
    logic [63:0] x_data;
    bit x_mis, x_err, x_req;
    logic [31:0] x_addr;
    logic [7:0] x_be;
    logic [63:0] x_wd;
  } vec_t;
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t tv(bit s, bit w, logic [2:0] f, logic [31:0] a, logic [63:0] wdat, logic [63:0] rdat,
                              int d1, int d2, bit e, bit both, int xd, logic [63:0] xdata, bit xm, bit xe, bit xr,
                              logic [31:0] xa, logic [7:0] xb, logic [63:0] xw);
    vec_t v;
    v.sel = s; v.we = w; v.f3 = f; v.addr = a; v.wd = wdat; v.rd = rdat; v.d1 = d1; v.d2 = d2;
    v.e = e; v.both = both; v.x_done = xd; v.x_data = xdata; v.x_mis = xm; v.x_err = xe;
    v.x_req = xr; v.x_addr = xa; v.x_be = xb; v.x_wd = xw;
    return v;
  endfunction
  // Reference: memory bytes are numbered by address; big endian puts byte 0 at the top of the
  // bus and makes the lowest-addressed byte the most significant one of the value.
  function automatic vec_t model(input vec_t v);
    int nb, sz, lane, k, pos;
    logic [63:0] val;
    bit uns;
    nb = v.sel ? 8 : 4;
    sz = 1 << v.f3[1:0];
    lane = int'(v.addr % nb);
    uns = v.we ? !(v.f3 <= 3'd2 || (v.f3 == 3'd3 && v.sel))
               : (v.f3 == 3'd7 || ((v.f3 == 3'd3 || v.f3 == 3'd6) && !v.sel));
    v.x_mis = !uns && (v.addr % sz != 0);
    v.x_req = !uns && !v.x_mis;
    v.x_err = uns || (v.x_req && v.e);
    v.x_done = v.x_req ? v.d1 + v.d2 + 3 : 1;
    v.x_addr = v.addr & ~32'(nb - 1);
    v.x_be = 0; v.x_wd = 0; val = 0;
    if (v.x_req)
      for (int i = 0; i < sz; i++) begin
        k = lane + i;
        pos = v.sel ? nb - 1 - k : k;
        if (v.we) begin
          v.x_be[k] = 1'b1;
          v.x_wd[8*pos +: 8] = v.wd[8*(v.sel ? sz - 1 - i : i) +: 8];
        end else
          val = v.sel ? ((val << 8) | 64'(v.rd[8*pos +: 8])) : (val | (64'(v.rd[8*pos +: 8]) << (8 * i)));
      end
    if (!v.f3[2] && sz < 8 && val[8*sz-1]) val = val | (~64'd0 << (8 * sz));
    if (!v.sel) val[63:32] = 32'd0;
    v.x_data = (v.x_req && !v.we && !v.e) ? val : 64'd0;
    return v;
  endfunction
  // Called at posedge+1 of cycle 0; returns at posedge+1 of the cycle after completion.
  task automatic run(input vec_t v, input string tag);
    int c, reqcnt, gcyc, done, stalls;
    bit seen, wen_c, req_at_done;
    logic [31:0] ad_c;
    logic [7:0] be_c;
    logic [63:0] wd_c, d;
    bit m, e;
    sel = v.sel; req_valid = 1; we = v.we; f3 = v.f3; addr = v.addr; wd = v.wd; rd = v.rd; derr = v.e;
    c = 0; reqcnt = 0; gcyc = -1; done = -1; stalls = 0; seen = 0;
    ad_c = 0; be_c = 0; wd_c = 0; wen_c = 0; d = 0; m = 0; e = 0; req_at_done = 0;
    while (done < 0 && c < 60) begin
      gnt = o_req && reqcnt == v.d1;
      rsp = (gcyc >= 0 && c == gcyc + 1 + v.d2) || (v.both && gnt);
      if (gnt) gcyc = c;
      if (o_req) begin
        if (!seen) begin ad_c = o_addr; be_c = o_be; wd_c = o_wd; wen_c = o_wen; end
        seen = 1;
        reqcnt++;
      end
      @(negedge clk);
      if (o_stall) stalls++;
      if (o_valid) begin done = c; d = o_data; m = o_mis; e = o_err; req_at_done = o_req; end
      @(posedge clk); #1;
      c++;
    end
    req_valid = 0; gnt = 0; rsp = 0;
    chk({tag, " done_cycle"}, 64'(done), 64'(v.x_done));
    chk({tag, " data"}, d, v.x_data);
    chk({tag, " misaligned"}, 64'(m), 64'(v.x_mis));
    chk({tag, " err"}, 64'(e), 64'(v.x_err));
    chk({tag, " stall_cycles"}, 64'(stalls), 64'(v.x_done));
    chk({tag, " req_issued"}, 64'(seen), 64'(v.x_req));
    chk({tag, " req_in_done"}, 64'(req_at_done), 64'd0);
    chk({tag, " after_done"}, {62'd0, o_valid, o_req}, 64'd0);
    if (v.x_req) begin
      chk({tag, " addr"}, 64'(ad_c), 64'(v.x_addr));
      chk({tag, " wr_en"}, 64'(wen_c), 64'(v.we));
      chk({tag, " wr_be"}, 64'(be_c), 64'(v.x_be));
      if (v.we) chk({tag, " wr_data"}, wd_c, v.x_wd);
    end
  endtask
  vec_t tbl[$];
  vec_t rv;
  initial begin
    tbl.push_back(tv(0,0,3'b000,32'h1003,0,64'h80FF_FF00,0,0,0,0, 3,64'hFFFF_FF80,0,0,1,32'h1000,0,0));
    tbl.push_back(tv(0,1,3'b001,32'h2002,64'h1234,0,0,0,0,0, 3,0,0,0,1,32'h2000,8'h0C,64'h1234_0000));
    tbl.push_back(tv(0,0,3'b010,32'h1001,0,0,0,0,0,0, 1,0,1,0,0,0,0,0));
    tbl.push_back(tv(1,0,3'b110,32'h8,0,64'hDEAD_BEEF_0000_0001,0,0,0,0, 3,64'h0000_0000_DEAD_BEEF,0,0,1,32'h8,0,0));
    tbl.push_back(tv(0,0,3'b011,32'h10,0,0,0,0,0,0, 1,0,0,1,0,0,0,0));
    tbl.push_back(tv(0,0,3'b100,32'h1003,0,64'h80FF_FF00,0,0,0,0, 3,64'h80,0,0,1,32'h1000,0,0));
    tbl.push_back(tv(1,0,3'b011,32'h10,0,64'h0123_4567_89AB_CDEF,1,0,0,0, 4,64'h0123_4567_89AB_CDEF,0,0,1,32'h10,0,0));
    tbl.push_back(tv(1,1,3'b000,32'h3,64'hAB,0,0,0,0,0, 3,0,0,0,1,32'h0,8'h08,64'h0000_00AB_0000_0000));
    tbl.push_back(tv(0,0,3'b001,32'h2,0,64'h8001_0000,0,0,1,0, 3,0,0,1,1,32'h0,0,0));
    tbl.push_back(tv(0,0,3'b111,32'h0,0,0,0,0,0,0, 1,0,0,1,0,0,0,0));
    tbl.push_back(tv(0,1,3'b100,32'h0,64'h55,0,0,0,0,0, 1,0,0,1,0,0,0,0));
    tbl.push_back(tv(1,0,3'b001,32'h6,0,64'hF00D,2,1,0,0, 6,64'hFFFF_FFFF_FFFF_F00D,0,0,1,32'h0,0,0));
    tbl.push_back(tv(0,1,3'b010,32'h4,64'hCAFE_BABE,0,0,0,0,0, 3,0,0,0,1,32'h4,8'h0F,64'hCAFE_BABE));
    tbl.push_back(tv(0,0,3'b010,32'h0,0,0,100,0,0,0, 5,0,0,1,1,32'h0,0,0));
    tbl.push_back(tv(0,0,3'b010,32'h0,0,64'h1234_5678,0,1,0,1, 4,64'h1234_5678,0,0,1,32'h0,0,0));
    tbl.push_back(tv(1,1,3'b011,32'h8,64'h1122_3344_5566_7788,0,0,0,0,0, 3,0,0,0,1,32'h8,8'hFF,64'h1122_3344_5566_7788));
    tbl.push_back(tv(1,1,3'b011,32'h4,64'h1,0,0,0,0,0, 1,0,1,0,0,0,0,0));
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset outputs32", {a_stall, a_valid, a_mis, a_err, a_req, a_wen, a_be, a_addr, a_data}, 0);
    chk("reset outputs64", {b_stall, b_valid, b_mis, b_err, b_req, b_wen, b_be, b_addr}, 0);
    chk("reset data64", b_data | b_wd, 0);
    @(posedge clk); #1;
    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));
    // reset while waiting in RSP, then a late response
    sel = 0; we = 0; f3 = 3'b010; addr = 32'h40; rd = 64'h7777_7777; derr = 0; req_valid = 1;
    @(posedge clk); #1;
    gnt = a_req;
    @(posedge clk); #1;
    gnt = 0; rst = 1; req_valid = 0;
    @(posedge clk); #1;
    rst = 0; rsp = 1;
    chk("rst req_low", 64'(a_req), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst quiet%0d", i), {a_stall, a_valid, a_mis, a_err, a_req, a_wen, a_be, a_addr, a_data, a_wd}, 0);
      @(posedge clk); #1;
      rsp = 0;
    end
    for (int i = 0; i < 250; i++) begin
      rv = tv($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom_range(0, 255),
              {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, $urandom_range(0, 7) == 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if ($urandom_range(0, 2) != 0) rv.addr = rv.addr & ~(32'd1 << rv.f3[1:0]) + 32'd1 & ~((32'd1 << rv.f3[1:0]) - 32'd1);
      if (rv.sel) begin
        rv.d1 = $urandom_range(0, 3);
        rv.d2 = $urandom_range(0, 3);
      end else begin
        rv.d1 = $urandom_range(0, 1);
        rv.d2 = rv.d1 ? 0 : $urandom_range(0, 1);
      end
      run(model(rv), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
